// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs a req/ack fetch to instruction
// memory and holds one fetched word for the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc_plus4,
  output logic [31:0] instruction,
  output logic        valid,
  output logic        stall_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        valid_q, valid_d;

  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target = {branch_addr[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC_ALIGNED;
      req_addr_q <= RESET_PC_ALIGNED;
      inst_buf_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inst_buf_q <= inst_buf_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inst_buf_d = inst_buf_q;
    valid_d    = valid_q;

    unique case (state_q)
      IDLE: begin
        state_d    = FETCH;
        req_addr_d = pc_q;
        if (branch_taken) begin
          pc_d       = target;
          req_addr_d = target;
        end
      end

      FETCH: begin
        if (branch_taken) begin
          pc_d = target;
          if (imem_ack) begin
            // Returned word belongs to the squashed path; reissue at the target.
            req_addr_d = target;
          end else begin
            // Old request is still in flight and must complete before we move on.
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          inst_buf_d = imem_rdata;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end

      DRAIN: begin
        if (branch_taken) begin
          pc_d = target;
        end
        if (imem_ack) begin
          state_d    = FETCH;
          req_addr_d = branch_taken ? target : pc_q;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_d       = target;
          req_addr_d = target;
          valid_d    = 1'b0;
          state_d    = FETCH;
        end else if (!freeze) begin
          pc_d       = pc_inc;
          req_addr_d = pc_inc;
          valid_d    = 1'b0;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = req_addr_q;
  assign pc_plus4    = pc_inc;
  assign instruction = inst_buf_q;
  assign valid       = valid_q;
  assign stall_if    = ~valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a table of scripted cycles, hand-written corner
// sequences, then random traffic checked against a flag-based fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc_plus4;
  logic [31:0] instruction;
  logic        valid;
  logic        stall_if;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .pc_plus4     (pc_plus4),
    .instruction  (instruction),
    .valid        (valid),
    .stall_if     (stall_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a PC, the address in flight, and flags for "request
  // outstanding", "word held", "started after reset", "in-flight word is dead".
  logic [31:0] m_pc, m_req, m_buf;
  logic        m_busy, m_have, m_started, m_stale;

  // Memory emulation: ack after 'lat' wait cycles of the current request.
  int   lat = 0;
  int   wait_cnt = 0;
  logic cur_req = 1'b0;

  typedef struct {
    logic        br;
    logic [31:0] ba;
    logic        frz;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t tbl [22];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_req     = RESET_PC;
    m_buf     = 32'd0;
    m_busy    = 1'b0;
    m_have    = 1'b0;
    m_started = 1'b0;
    m_stale   = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    tgt = {branch_addr[31:2], 2'b00};
    if (!m_started) begin
      if (branch_taken) m_pc = tgt;
      m_req     = m_pc;
      m_busy    = 1'b1;
      m_started = 1'b1;
    end else if (m_busy) begin
      if (imem_ack) begin
        if (m_stale || branch_taken) begin
          if (branch_taken) m_pc = tgt;
          m_req   = m_pc;
          m_stale = 1'b0;
        end else begin
          m_buf  = imem_rdata;
          m_have = 1'b1;
          m_busy = 1'b0;
          $display("[%0t] fetched addr=%h inst=%h", $time, m_req, m_buf);
        end
      end else if (branch_taken) begin
        m_pc    = tgt;
        m_stale = 1'b1;
      end
    end else if (m_have) begin
      if (branch_taken) begin
        m_pc   = tgt;
        m_req  = tgt;
        m_have = 1'b0;
        m_busy = 1'b1;
      end else if (!freeze) begin
        m_pc   = m_pc + 32'd4;
        m_req  = m_pc;
        m_have = 1'b0;
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    check("mdl_req",   {31'd0, imem_req}, {31'd0, m_busy});
    check("mdl_addr",  imem_addr, m_req);
    check("mdl_valid", {31'd0, valid}, {31'd0, m_have});
    check("mdl_stall", {31'd0, stall_if}, {31'd0, !m_have});
    check("mdl_pc4",   pc_plus4, m_pc + 32'd4);
    check("mdl_inst",  instruction, m_buf);
  endtask

  task automatic drive(input logic br, input logic [31:0] ba, input logic frz);
    branch_taken = br;
    branch_addr  = ba;
    freeze       = frz;
    cur_req      = imem_req;
    imem_ack     = imem_req && !rst && (wait_cnt >= lat);
    imem_rdata   = imem_ack ? inst_of(imem_addr) : ($urandom() | 32'h1);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    if (rst || !cur_req || imem_ack) wait_cnt = 0;
    else                             wait_cnt++;
    #1;
    compare_model();
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!valid && k < 20) begin
      drive(1'b0, 32'd0, 1'b0);
      cycle();
      k++;
    end
    check(name, {31'd0, valid}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    model_reset();

    // Zero-wait memory: sequential fetch, freeze hold, branch in HOLD, branch+ack.
    tbl[0]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1'b0, 32'h4};
    tbl[1]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h4};
    tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1'b0, 32'h8};
    tbl[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h4,   1'b1, 32'h8};
    tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b0, 32'hC};
    tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h8,   1'b1, 32'hC};
    tbl[6]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   1'b0, 32'h10};
    tbl[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'hC,   1'b1, 32'h10};
    tbl[8]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b0, 32'h14};
    tbl[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 32'h14};
    tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b1, 32'h14};
    tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b1, 32'h14};
    tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b1, 32'h14};
    tbl[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b1, 32'h14};
    tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b1, 32'h14};
    tbl[15] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h14,  1'b0, 32'h18};
    tbl[16] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h14,  1'b1, 32'h18};
    tbl[17] = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h204};
    tbl[18] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h200, 1'b1, 32'h204};
    tbl[19] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0, 32'h208};
    tbl[20] = '{1'b1, 32'h303, 1'b0, 1'b1, 32'h300, 1'b0, 32'h304};
    tbl[21] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h300, 1'b1, 32'h304};

    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_pc4",   pc_plus4, RESET_PC + 32'd4);
    check("rst_inst",  instruction, 32'd0);
    check("rst_stall", {31'd0, stall_if}, 32'd1);
    compare_model();
    rst = 1'b0;

    lat = 0;
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].br, tbl[i].ba, tbl[i].frz);
      cycle();
      check("tbl_req",   {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
      check("tbl_addr",  imem_addr, tbl[i].exp_addr);
      check("tbl_valid", {31'd0, valid}, {31'd0, tbl[i].exp_valid});
      check("tbl_pc4",   pc_plus4, tbl[i].exp_pc4);
      if (tbl[i].exp_valid) check("tbl_inst", instruction, inst_of(tbl[i].exp_addr));
    end

    // Three-cycle memory: request held at a stable address, stall throughout.
    lat = 2;
    drive(1'b0, 32'd0, 1'b0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      check("lat_req",   {31'd0, imem_req}, 32'd1);
      check("lat_addr",  imem_addr, 32'h304);
      check("lat_stall", {31'd0, stall_if}, 32'd1);
      drive(1'b0, 32'd0, 1'b0);
      cycle();
    end
    check("lat_valid", {31'd0, valid}, 32'd1);
    check("lat_inst",  instruction, inst_of(32'h304));
    check("lat_pc4",   pc_plus4, 32'h308);

    // Branch while a fetch is outstanding: old request drained, data dropped.
    drive(1'b1, 32'h20, 1'b0);
    cycle();
    check("dr_addr0", imem_addr, 32'h20);
    drive(1'b1, 32'h103, 1'b0);
    cycle();
    check("dr_req",  {31'd0, imem_req}, 32'd1);
    check("dr_addr", imem_addr, 32'h20);
    check("dr_pc4",  pc_plus4, 32'h104);
    drive(1'b0, 32'd0, 1'b0);
    cycle();
    check("dr_addr_hold", imem_addr, 32'h20);
    drive(1'b0, 32'd0, 1'b0);
    cycle();
    check("dr_refetch", imem_addr, 32'h100);
    check("dr_novalid", {31'd0, valid}, 32'd0);
    check("dr_inst_kept", instruction, inst_of(32'h304));
    wait_valid("dr_valid");
    check("dr_inst", instruction, inst_of(32'h100));
    check("dr_pc4b", pc_plus4, 32'h104);

    // Wrap at the top of the address space.
    lat = 0;
    drive(1'b1, 32'hFFFF_FFFE, 1'b0);
    cycle();
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 32'd0, 1'b0);
    cycle();
    check("wr_pc4",  pc_plus4, 32'h0);
    check("wr_inst", instruction, inst_of(32'hFFFF_FFFC));
    drive(1'b0, 32'd0, 1'b0);
    cycle();
    check("wr_next", imem_addr, 32'h0);

    // Asynchronous reset in the middle of a wait.
    lat = 6;
    drive(1'b0, 32'd0, 1'b0);
    cycle();
    #2;
    rst = 1'b1;
    imem_ack = 1'b0;
    #1;
    model_reset();
    check("arst_req",   {31'd0, imem_req}, 32'd0);
    check("arst_valid", {31'd0, valid}, 32'd0);
    check("arst_pc4",   pc_plus4, RESET_PC + 32'd4);
    drive(1'b0, 32'd0, 1'b0);
    cycle();
    rst = 1'b0;
    lat = 0;
    drive(1'b0, 32'd0, 1'b0);
    cycle();
    check("arst_first_req",  {31'd0, imem_req}, 32'd1);
    check("arst_first_addr", imem_addr, RESET_PC);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      logic        br;
      logic        frz;
      logic [31:0] ba;
      if (wait_cnt == 0) lat = $urandom_range(0, 3);
      br  = ($urandom_range(0, 7) == 0);
      frz = ($urandom_range(0, 2) == 0);
      ba  = $urandom();
      if ($urandom_range(0, 5) == 0) ba = 32'hFFFF_FFF0 | {28'd0, ba[3:0]};
      rst = ($urandom_range(0, 249) == 0);
      drive(br, ba, frz);
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
